// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin through a single full-subtractor cell, LSB first.
// Latency: start accepted at edge N -> done pulse and diff/bout valid from edge N+WIDTH.
// Backpressure: none; start is ignored while busy, results are held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter indexes bits 0..WIDTH-1; WIDTH >= 2 keeps clog2 at least 1.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bo;

    // One full-subtractor cell acting on the current LSBs and the running borrow.
    always_comb begin
        d  = sa[0] ^ sb[0] ^ br;
        bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    end

    // Control FSM and datapath: capture operands on start, then retire one bit per clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            // done is a single-cycle strobe.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= {d, sr[WIDTH-1:1]};
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    // Last bit: publish the assembled result including this cycle's bit.
                    if (cnt == LAST) begin
                        diff  <= {d, sr[WIDTH-1:1]};
                        bout  <= bo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results, monitor checks done pulses.
// Latency: checks each result arrives exactly WIDTH edges after its accepting edge.
// Backpressure: driver only issues while busy is low; starts issued while busy must be ignored.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         bin8 = 1'b0;
    logic         busy8;
    logic         done8;
    logic [7:0]   diff8;
    logic         bout8;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W:0] val;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clock) cyc++;

    // Reference: {bout,diff} is a - b - bin as a (W+1)-bit two's-complement value.
    function automatic logic [W:0] model(input int av, input int bv, input int bi);
        int d;
        d = av - bv - bi;
        return (W+1)'(d);
    endfunction

    // Monitor: compare every done pulse with the oldest expectation; watch busy and timing.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_done cyc=%0d got {bout,diff}=%h", cyc, {bout, diff});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bout, diff} !== mon_e.val || cyc != mon_e.due || busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL result got {bout,diff}=%h at cyc %0d busy=%b, want %h at cyc %0d busy=0",
                                 {bout, diff}, cyc, busy, mon_e.val, mon_e.due);
                    end
                end
            end else if (exp_q.size() > 0) begin
                if (cyc >= exp_q[0].due) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_done cyc=%0d want %h due at %0d", cyc, exp_q[0].val, exp_q[0].due);
                    void'(exp_q.pop_front());
                end else if (cyc >= exp_q[0].due - W) begin
                    n_vec++;
                    if (busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL busy_during_run cyc=%0d got %b want 1", cyc, busy);
                    end
                end
            end
        end
    end

    // Issue one operation as soon as the DUT is idle; call at a negedge.
    task automatic issue(input int av, input int bv, input int bi);
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout busy=%b want 0", busy);
        end
        start = 1'b1;
        a     = W'(av);
        b     = W'(bv);
        bin   = bi[0];
        exp_q.push_back('{val: model(av, bv, bi), due: cyc + 1 + W});
        @(negedge clock);
        start = 1'b0;
    endtask

    // While busy: pulse start and scramble operands; none of it may disturb the running op.
    task automatic noise();
        int k;
        k = $urandom_range(1, W - 1);
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        repeat (k) begin
            @(negedge clock);
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        int k;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if ({busy, done, diff, bout} !== '0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
        end
        reset = 1'b0;
        @(negedge clock);

        // Directed cases, back-to-back, including ignored start while busy on 9-2.
        issue(7, 3, 0);
        issue(3, 7, 0);
        issue(0, 0, 1);
        issue(15, 15, 0);
        issue(9, 2, 0);
        noise();
        issue(5, 6, 0);

        // Exhaustive sweep with occasional busy-time noise and idle gaps.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    issue(ai, bi, ci);
                    if ($urandom_range(0, 3) == 0) noise();
                    if ($urandom_range(0, 7) == 0) repeat (W + 2) @(negedge clock);
                end
            end
        end

        // Random operands.
        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) noise();
        end

        // Mid-operation asynchronous reset on 12-5.
        issue(12, 5, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, diff, bout} !== '0) begin
            n_err++;
            $display("FAIL async_reset got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
        end
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (2 * W) @(negedge clock);
        issue(12, 5, 0);

        // Drain the scoreboard.
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        // WIDTH=8 spot check: 200-57.
        start8 = 1'b1;
        a8     = 8'd200;
        b8     = 8'd57;
        bin8   = 1'b0;
        k = 0;
        @(negedge clock);
        k++;
        start8 = 1'b0;
        a8     = 8'd3;
        b8     = 8'd99;
        while (!done8 && k < 40) begin
            @(negedge clock);
            k++;
        end
        n_vec++;
        if (done8 !== 1'b1 || k != 9 || diff8 !== 8'd143 || bout8 !== 1'b0) begin
            n_err++;
            $display("FAIL width8 got done=%b after %0d diff=%0d bout=%b want done=1 after 9 diff=143 bout=0",
                     done8, k, diff8, bout8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
